// File: rtl/beep_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : beep_sched                                                    |
// | Purpose  : Non-preemptive buzzer scheduler serving NREQ beep-burst       |
// |            requests. Optional round-robin arbitration: BEEP_SCHED_RR_EN. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module beep_sched #(
  parameter int NREQ      = 4,
  parameter int TICK_DIV  = 25000,
  parameter int TONE_HALF = 6250,
  parameter int ON_MS     = 100,
  parameter int OFF_MS    = 100
) (
  input  logic              ext_clk_25m,
  input  logic              ext_rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] cnt_i,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic              beep
);

  localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW     = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
  localparam int MS_MAX = (ON_MS > OFF_MS) ? ON_MS : OFF_MS;
  localparam int MW     = $clog2(MS_MAX + 1);

  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TONE_LAST = TW'(TONE_HALF - 1);
  localparam logic [MW-1:0] ON_LAST   = MW'(ON_MS - 1);
  localparam logic [MW-1:0] OFF_LAST  = MW'(OFF_MS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [2:0]      rem_q, rem_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [MW-1:0]   ms_q, ms_d;
  logic [TW-1:0]   tone_q, tone_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            busy_q, busy_d;
  logic            beep_q, beep_d;

  logic            win_vld;
  logic [IW-1:0]   win_idx;
  logic [2:0]      cnt_arr [NREQ];
  logic            tick;
  logic            tone_wrap;
  logic            expire;
  logic [MW-1:0]   ms_last;

  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    assign cnt_arr[g] = cnt_i[3*g +: 3];
  end

`ifdef BEEP_SCHED_RR_EN
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] cand;

  // Walk downwards so the requester closest after the pointer is kept last.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IW'((int'(ptr_q) + k) % NREQ);
      if (req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == S_FIN) ptr_d = idx_q;
  end

  always_ff @(posedge ext_clk_25m or negedge ext_rst_n) begin
    if (!ext_rst_n) ptr_q <= IW'(NREQ - 1);
    else            ptr_q <= ptr_d;
  end
`else
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[IW'(i)]) begin
        win_vld = 1'b1;
        win_idx = IW'(i);
      end
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rem_d     = rem_q;
    pre_d     = pre_q;
    ms_d      = ms_q;
    tone_d    = tone_q;
    beep_d    = 1'b0;
    done_d    = '0;
    grant_d   = '0;
    tick      = (pre_q == PRE_LAST);
    tone_wrap = (tone_q == TONE_LAST);
    ms_last   = (state_q == S_ON) ? ON_LAST : OFF_LAST;
    expire    = tick && (ms_q == ms_last);

    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d = S_ON;
          idx_d   = win_idx;
          rem_d   = (cnt_arr[win_idx] == 3'd0) ? 3'd1 : cnt_arr[win_idx];
          pre_d   = '0;
          ms_d    = '0;
          tone_d  = '0;
          beep_d  = 1'b1;
        end
      end
      S_ON, S_OFF: begin
        // Dropping req aborts the burst; this outranks a coincident expiry.
        if (!req[idx_q]) begin
          state_d = S_IDLE;
          pre_d   = '0;
          ms_d    = '0;
          tone_d  = '0;
        end else if (expire) begin
          pre_d  = '0;
          ms_d   = '0;
          tone_d = '0;
          if (state_q == S_ON) begin
            rem_d   = rem_q - 3'd1;
            state_d = (rem_q == 3'd1) ? S_FIN : S_OFF;
          end else begin
            state_d = S_ON;
            beep_d  = 1'b1;
          end
        end else begin
          pre_d = tick ? '0 : pre_q + 1'b1;
          ms_d  = ms_q + MW'(tick);
          if (state_q == S_ON) begin
            tone_d = tone_wrap ? '0 : tone_q + 1'b1;
            beep_d = tone_wrap ? ~beep_q : beep_q;
          end
        end
      end
      S_FIN: begin
        state_d       = S_IDLE;
        done_d[idx_q] = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    if (busy_d) grant_d[idx_d] = 1'b1;
  end

  always_ff @(posedge ext_clk_25m or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      pre_q   <= '0;
      ms_q    <= '0;
      tone_q  <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      beep_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      pre_q   <= pre_d;
      ms_q    <= ms_d;
      tone_q  <= tone_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      beep_q  <= beep_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign beep  = beep_q;

endmodule
`default_nettype wire

// File: tb/tb_beep_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_beep_sched                                                 |
// | Purpose  : Self-checking bench for beep_sched with a timeline model.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_beep_sched;

  localparam int ONC  = 30;  // ON_MS * TICK_DIV
  localparam int OFFC = 20;  // OFF_MS * TICK_DIV
  localparam int PER  = ONC + OFFC;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req   = 4'b0;
  logic [11:0] cnt   = 12'b0;
  logic [3:0]  grant, done;
  logic        busy, beep;

  int n_chk  = 0;
  int n_fail = 0;

  beep_sched #(
    .NREQ(4), .TICK_DIV(10), .TONE_HALF(2), .ON_MS(3), .OFF_MS(2)
  ) dut (
    .ext_clk_25m(clk), .ext_rst_n(rst_n), .req(req), .cnt_i(cnt),
    .grant(grant), .done(done), .busy(busy), .beep(beep)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a served burst is a timeline position k (0 = first cycle after the
  // sampling edge); n beeps occupy n*PER-OFFC cycles, then one FIN cycle,
  // then a done cycle that is also the first idle cycle.
  function automatic int pick(input logic [3:0] r, input int ptr);
    int idx;
`ifdef BEEP_SCHED_RR_EN
    for (int j = 1; j <= 4; j++) begin
      idx = (ptr + j) % 4;
      if (r[idx[1:0]]) return idx;
    end
`else
    for (int j = 0; j < 4; j++) begin
      idx = j + 0 * ptr;
      if (r[idx[1:0]]) return idx;
    end
`endif
    return -1;
  endfunction

  int   m_k = 0, m_n = 1, m_win = 0, m_ptr = 3, m_pick, m_cnt;
  bit   m_act = 0, m_donec = 0;
  logic [3:0] e_grant, e_done;
  logic       e_busy, e_beep;

  always_comb begin
    m_pick = pick(req, m_ptr);
    m_cnt  = 1;
    if (m_pick >= 0) begin
      m_cnt = int'((cnt >> (3 * m_pick)) & 12'h7);
      if (m_cnt == 0) m_cnt = 1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act <= 0; m_donec <= 0; m_k <= 0; m_ptr <= 3;
    end else if (m_act) begin
      if (m_k < m_n * PER - OFFC) begin
        if (((req >> m_win) & 4'b1) == 4'b0) m_act <= 0;
        else m_k <= m_k + 1;
      end else begin
        m_act <= 0; m_donec <= 1; m_ptr <= m_win;
      end
    end else begin
      m_donec <= 0;
      if (m_pick >= 0) begin
        m_act <= 1; m_win <= m_pick; m_k <= 0; m_n <= m_cnt;
      end
    end
  end

  always_comb begin
    e_grant = 4'b0; e_done = 4'b0; e_busy = 1'b0; e_beep = 1'b0;
    if (m_act) begin
      e_grant = 4'b0001 << m_win;
      e_busy  = 1'b1;
      if (m_k < m_n * PER - OFFC && (m_k % PER) < ONC && ((m_k % PER) / 2) % 2 == 0)
        e_beep = 1'b1;
    end else if (m_donec) begin
      e_done = 4'b0001 << m_win;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_grant", 32'(grant), 32'(e_grant));
      chk("cyc_done",  32'(done),  32'(e_done));
      chk("cyc_busy",  32'(busy),  32'(e_busy));
      chk("cyc_beep",  32'(beep),  32'(e_beep));
    end
  end

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  function automatic int oh2i(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $fatal(1);
  end

  initial begin
    int hi, dk, mdk, nd, nfd;
    int ord [4];
    logic [3:0] pat;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_done",  32'(done),  0);
    chk("rst_busy",  32'(busy),  0);
    chk("rst_beep",  32'(beep),  0);
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) tick1();

    // Two-beep burst on requester 1.
    cnt = {3'd0, 3'd0, 3'd2, 3'd0};
    req = 4'b0010;
    tick1();
    chk("t1_grant", 32'(grant), 32'h2);
    chk("t1_busy",  32'(busy),  1);
    chk("t1_model_grant", 32'(e_grant), 32'h2);
    hi = int'(beep); dk = -1; mdk = -1; pat = 4'b0;
    pat[0] = beep;
    for (int k = 1; k <= 90; k++) begin
      tick1();
      if (k <= 3) pat[k] = beep;
      hi += int'(beep);
      if (e_done[1] && mdk < 0) mdk = k;
      if (done[1] && dk < 0) begin dk = k; req[1] = 1'b0; end
    end
    req = 4'b0;
    chk("t1_pattern", 32'(pat), 32'h3);
    chk("t1_beep_hi", hi, 32);
    chk("t1_done_at", dk, 81);
    chk("t1_model_done_at", mdk, 81);

    // Count 0 behaves as a single beep.
    cnt = 12'b0;
    req = 4'b0100;
    tick1();
    chk("t2_grant", 32'(grant), 32'h4);
    hi = int'(beep); dk = -1;
    for (int k = 1; k <= 40; k++) begin
      tick1();
      hi += int'(beep);
      if (done[2] && dk < 0) begin dk = k; req[2] = 1'b0; end
    end
    req = 4'b0;
    chk("t2_beep_hi", hi, 16);
    chk("t2_done_at", dk, 31);

    // Requester 0 arrives mid-burst, waits, then aborts in its OFF gap.
    cnt = {3'd1, 3'd0, 3'd0, 3'd2};
    req = 4'b1000;
    tick1();
    chk("t3_grant3", 32'(grant), 32'h8);
    dk = -1; nd = 0;
    for (int k = 1; k <= 130; k++) begin
      tick1();
      if (k == 10) req[0] = 1'b1;
      if (done[3] && dk < 0) begin dk = k; req[3] = 1'b0; end
      if (k == 32) chk("t3_grant0", 32'(grant), 32'h1);
      if (k > 32 && done != 4'b0) nd++;
      if (k == 67) begin
        chk("t3_off_busy", 32'(busy), 1);
        req[0] = 1'b0;
      end
      if (k == 68) begin
        chk("t3_abort_grant", 32'(grant), 0);
        chk("t3_abort_busy",  32'(busy),  0);
        chk("t3_abort_beep",  32'(beep),  0);
      end
    end
    chk("t3_done3_at", dk, 31);
    chk("t3_no_done", nd, 0);

    // Asynchronous reset mid-beep, then full restart.
    cnt = {3'd0, 3'd0, 3'd3, 3'd0};
    req = 4'b0010;
    tick1();
    repeat (5) tick1();
    chk("t4_pre_beep", 32'(beep), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("t4_rst_beep",  32'(beep),  0);
    chk("t4_rst_grant", 32'(grant), 0);
    chk("t4_rst_busy",  32'(busy),  0);
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b1;
    tick1();
    chk("t4_regrant", 32'(grant), 32'h2);
    dk = -1;
    for (int k = 1; k <= 140; k++) begin
      tick1();
      if (done[1] && dk < 0) begin dk = k; req[1] = 1'b0; end
    end
    req = 4'b0;
    chk("t4_done_at", dk, 131);

    // All four request; each drops after its done.
    cnt = 12'b0;
    req = 4'b1111;
    nd = 0;
    for (int k = 0; k < 150; k++) begin
      tick1();
      if (done != 4'b0) begin
        if (nd < 4) ord[nd] = oh2i(done);
        nd++;
        req = req & ~done;
      end
    end
    chk("t5_count", nd, 4);
    for (int i = 0; i < 4; i++) chk("t5_order", ord[i], i);

    // All four held: fixed priority keeps serving 0, round-robin rotates.
    req = 4'b1111;
    nd = 0; nfd = -1;
    for (int k = 0; k < 70; k++) begin
      tick1();
      if (done != 4'b0) begin
        if (nd == 0) nfd = oh2i(done);
        if (nd == 1) ord[0] = oh2i(done);
        nd++;
      end
    end
    req = 4'b0;
    repeat (5) tick1();
    chk("t6_count", nd, 2);
    chk("t6_first", nfd, 0);
`ifdef BEEP_SCHED_RR_EN
    chk("t6_second", ord[0], 1);
`else
    chk("t6_second", ord[0], 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
